// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding, default widths and the reserved-bit masks.
package loader_pkg;

    localparam int unsigned ADDR_W_DEF  = 12;
    localparam int unsigned INSTR_W_DEF = 19;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 12;

    // Header high byte carries only the top nibble of the word count.
    localparam logic [BYTE_W-1:0] HDR_HI_RSVD_MASK = 8'hF0;
    // First byte of a word carries only instruction bits [18:16].
    localparam logic [BYTE_W-1:0] B0_RSVD_MASK     = 8'hF8;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_B0     = 3'd2,
        ST_B1     = 3'd3,
        ST_B2     = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s != ST_DONE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and processor-reset
// bundle of the program loader; master is the loader, slave its environment.
interface program_loader_if #(
    parameter int unsigned ADDR_W  = loader_pkg::ADDR_W_DEF,
    parameter int unsigned INSTR_W = loader_pkg::INSTR_W_DEF
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;
    logic               cpu_rst;
    logic               done;
    logic               error;

    modport master (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses HDR_HI, HDR_LO, N x (B0,B1,B2), CSUM from a byte stream,
// writes 19-bit words to instruction memory and releases cpu_rst on success.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    program_loader_if.master   bus
);

    localparam int unsigned PART_W = INSTR_W - BYTE_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PART_W-1:0]   r_partial;
    logic [CNT_W-1:0]    r_remaining;
    logic [BYTE_W-1:0]   r_csum;
    logic                r_im_we;
    logic [ADDR_W-1:0]   r_im_addr;
    logic [INSTR_W-1:0]  r_im_wdata;

    logic                w_ready;
    logic                w_accept;
    logic [CNT_W-1:0]    w_hdr_count;
    logic                w_hdr_rsvd;
    logic                w_b0_rsvd;

    assign w_ready     = !rst && is_loading(r_state);
    assign w_accept    = bus.in_valid && w_ready;
    // r_remaining holds the header high nibble until HDR_LO arrives.
    assign w_hdr_count = {r_remaining[CNT_W-1 -: 4], bus.in_data};
    assign w_hdr_rsvd  = |(bus.in_data & HDR_HI_RSVD_MASK);
    assign w_b0_rsvd   = |(bus.in_data & B0_RSVD_MASK);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; without an accepted byte the FSM simply holds
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_HDR_HI: w_state_nxt = w_hdr_rsvd ? ST_ERROR : ST_HDR_LO;
                ST_HDR_LO: w_state_nxt = (w_hdr_count == '0) ? ST_CSUM : ST_B0;
                ST_B0:     w_state_nxt = w_b0_rsvd ? ST_ERROR : ST_B1;
                ST_B1:     w_state_nxt = ST_B2;
                ST_B2:     w_state_nxt = (r_remaining == CNT_W'(1)) ? ST_CSUM : ST_B0;
                ST_CSUM:   w_state_nxt = (bus.in_data == r_csum) ? ST_DONE : ST_ERROR;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        bus.in_ready = w_ready;
        bus.im_we    = r_im_we;
        bus.im_addr  = r_im_addr;
        bus.im_wdata = r_im_wdata;
        bus.done     = (r_state == ST_DONE);
        bus.error    = (r_state == ST_ERROR);
        bus.cpu_rst  = (r_state != ST_DONE);
    end

    // Datapath: word assembly, remaining-word count, XOR checksum, write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_partial   <= '0;
            r_remaining <= '0;
            r_csum      <= '0;
            r_im_we     <= 1'b0;
            r_im_addr   <= '0;
            r_im_wdata  <= '0;
        end else begin
            r_im_we <= 1'b0;
            if (r_im_we) begin
                r_im_addr <= r_im_addr + ADDR_W'(1);
            end
            if (w_accept) begin
                if (r_state != ST_CSUM) begin
                    r_csum <= r_csum ^ bus.in_data;
                end
                case (r_state)
                    ST_HDR_HI: r_remaining <= CNT_W'({bus.in_data[3:0], 8'h00});
                    ST_HDR_LO: r_remaining <= w_hdr_count;
                    ST_B0:     r_partial   <= PART_W'(bus.in_data[2:0]);
                    ST_B1:     r_partial   <= {r_partial[PART_W-BYTE_W-1:0], bus.in_data};
                    ST_B2: begin
                        r_im_we     <= 1'b1;
                        r_im_wdata  <= {r_partial, bus.in_data};
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: good, bad-checksum, empty,
// reserved-bit, gapped and mid-load-reset images with hand-computed results.
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [11:0] wr_addr[$];
    logic [18:0] wr_data[$];
    int unsigned wr_cyc[$];

    program_loader_if bus ();

    program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe away from the active edge
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_addr.push_back(bus.im_addr);
            wr_data.push_back(bus.im_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Call at a negedge; returns at the negedge after the last byte's edge
    task automatic send_image(input bq_t img, input int gap, output int unsigned c0);
        c0 = cyc;
        foreach (img[i]) begin
            repeat (gap) @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            check_eq($sformatf("in_ready_b%0d", i), 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_two_words(input string tag, input int unsigned c0, input int gap);
        check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'h000);
            check_eq({tag, "_d0"}, 32'(wr_data[0]), 32'h12345);
            check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'h001);
            check_eq({tag, "_d1"}, 32'(wr_data[1]), 32'h6789A);
            check_eq({tag, "_wcyc0"}, wr_cyc[0] - c0, 32'(5 * (gap + 1)));
            check_eq({tag, "_wgap"}, wr_cyc[1] - wr_cyc[0], 32'(3 * (gap + 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good, badcs, empty, badhdr, badb0, partial;
        int unsigned c0;

        good    = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h81};
        badcs   = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, 8'h80};
        empty   = '{8'h00, 8'h00, 8'h00};
        badhdr  = '{8'h10};
        badb0   = '{8'h00, 8'h01, 8'h09};
        partial = '{8'h00, 8'h02, 8'h01, 8'h23};

        // Values while reset is held
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_im_we", 32'(bus.im_we), 32'd0);
        check_eq("rst_im_addr", 32'(bus.im_addr), 32'd0);
        check_eq("rst_im_wdata", 32'(bus.im_wdata), 32'd0);
        check_eq("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_error", 32'(bus.error), 32'd0);

        // Back-to-back two-word image
        do_reset();
        check_eq("idle_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        send_image(good, 0, c0);
        check_two_words("good", c0, 0);
        check_eq("good_done", 32'(bus.done), 32'd1);
        check_eq("good_done_cyc", cyc - c0, 32'd9);
        check_eq("good_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check_eq("good_error", 32'(bus.error), 32'd0);
        check_eq("good_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("good_done_held", 32'(bus.done), 32'd1);

        // Checksum mismatch
        do_reset();
        send_image(badcs, 0, c0);
        check_two_words("badcs", c0, 0);
        check_eq("badcs_error", 32'(bus.error), 32'd1);
        check_eq("badcs_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check_eq("badcs_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("badcs_done", 32'(bus.done), 32'd0);

        // Empty image
        do_reset();
        send_image(empty, 0, c0);
        check_eq("empty_done", 32'(bus.done), 32'd1);
        check_eq("empty_done_cyc", cyc - c0, 32'd3);
        check_eq("empty_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check_eq("empty_nwr", 32'(wr_addr.size()), 32'd0);

        // Reserved header bits
        do_reset();
        send_image(badhdr, 0, c0);
        check_eq("badhdr_error", 32'(bus.error), 32'd1);
        check_eq("badhdr_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("badhdr_nwr", 32'(wr_addr.size()), 32'd0);

        // Reserved B0 bits
        do_reset();
        send_image(badb0, 0, c0);
        check_eq("badb0_error", 32'(bus.error), 32'd1);
        check_eq("badb0_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("badb0_nwr", 32'(wr_addr.size()), 32'd0);

        // Three idle cycles ahead of every byte
        do_reset();
        send_image(good, 3, c0);
        check_two_words("gap", c0, 3);
        check_eq("gap_done", 32'(bus.done), 32'd1);
        check_eq("gap_done_cyc", cyc - c0, 32'd36);
        check_eq("gap_error", 32'(bus.error), 32'd0);

        // Reset mid-load, then a clean reload from address 0
        do_reset();
        send_image(partial, 0, c0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("midrst_im_addr", 32'(bus.im_addr), 32'd0);
        check_eq("midrst_im_we", 32'(bus.im_we), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_nwr", 32'(wr_addr.size()), 32'd0);
        send_image(good, 0, c0);
        check_two_words("reload", c0, 0);
        check_eq("reload_done", 32'(bus.done), 32'd1);
        check_eq("reload_cpu_rst", 32'(bus.cpu_rst), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
